// File: rtl/fb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fb_pkg
//  Brief    : Shared types and constants for the frame-buffer read arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package fb_pkg;

    localparam int FB_NUM_PIXELS = 76800;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_BLANK  = 2'd1,
        ST_FORCE  = 2'd2
    } fb_state_e;

    typedef enum logic [1:0] {
        REQ_NONE = 2'd0,
        REQ_VGA  = 2'd1,
        REQ_STR  = 2'd2
    } fb_req_e;

    // One response slot: who owns it, and whether the address was out of range.
    typedef struct packed {
        fb_req_e req;
        logic    oob;
    } fb_tag_t;

    localparam fb_tag_t FB_TAG_IDLE = '{req: REQ_NONE, oob: 1'b0};

endpackage
`default_nettype wire

// File: rtl/fb_read_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : fb_read_arbiter_if
//  Brief    : Requester, RAM and status signals of the frame-buffer arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface fb_read_arbiter_if #(
    parameter int ADDR_W = 17,
    parameter int DATA_W = 12
);
    logic              vga_blank;
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rvalid;
    logic              str_req;
    logic [ADDR_W-1:0] str_addr;
    logic              str_gnt;
    logic              str_rvalid;
    logic              ram_rd_en;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] rdata;
    logic              oob_err;
    logic [15:0]       str_grant_cnt;

    modport slave (
        input  vga_blank, vga_req, vga_addr, str_req, str_addr, ram_rdata,
        output vga_gnt, vga_rvalid, str_gnt, str_rvalid,
        output ram_rd_en, ram_addr, rdata, oob_err, str_grant_cnt
    );

    modport master (
        output vga_blank, vga_req, vga_addr, str_req, str_addr, ram_rdata,
        input  vga_gnt, vga_rvalid, str_gnt, str_rvalid,
        input  ram_rd_en, ram_addr, rdata, oob_err, str_grant_cnt
    );
endinterface
`default_nettype wire

// File: rtl/fb_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fb_tag_pipe
//  Brief    : Fixed-depth delay line carrying response ownership tags.
//  Revision : 1.0  initial release
// ============================================================================
module fb_tag_pipe
    import fb_pkg::*;
#(
    parameter int DEPTH = 3
) (
    input  wire     clk,
    input  wire     rst,
    input  fb_tag_t i_tag,
    output fb_tag_t o_tag
);

    fb_tag_t r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= FB_TAG_IDLE;
            end
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fb_read_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : fb_read_arbiter
//  Brief    : Two-requester frame-buffer read arbiter with starvation guard.
//  Revision : 1.0  initial release
// ============================================================================
module fb_read_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 12,
    parameter int NUM_PIXELS   = FB_NUM_PIXELS,
    parameter int RAM_LAT      = 2,
    parameter int STARVE_LIMIT = 64
) (
    input  wire              clk,
    input  wire              rst,
    fb_read_arbiter_if.slave bus
);

    localparam int c_pipe_depth = 1 + RAM_LAT;
    localparam int c_starve_w   = $clog2(STARVE_LIMIT + 1);
    localparam logic [c_starve_w-1:0] c_starve_trip = c_starve_w'(STARVE_LIMIT - 1);
    localparam logic [c_starve_w-1:0] c_starve_sat  = c_starve_w'(STARVE_LIMIT);
    localparam logic [ADDR_W:0]       c_num_pixels  = (ADDR_W + 1)'(NUM_PIXELS);

    fb_state_e             r_state;
    fb_state_e             w_state_nxt;
    logic [c_starve_w-1:0] r_starve_cnt;
    logic                  w_vga_gnt;
    logic                  w_str_gnt;
    logic                  w_any_gnt;
    logic                  w_gnt_oob;
    logic [ADDR_W-1:0]     w_gnt_addr;
    fb_tag_t               w_tag_in;
    fb_tag_t               w_tag_out;
    logic                  r_ram_rd_en;
    logic [ADDR_W-1:0]     r_ram_addr;
    logic                  r_oob_err;
    logic [15:0]           r_str_grant_cnt;
    logic                  w_vga_rvalid;
    logic                  w_str_rvalid;
    logic [DATA_W-1:0]     w_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_ACTIVE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_vga_gnt   = 1'b0;
        w_str_gnt   = 1'b0;
        case (r_state)
            ST_ACTIVE: begin
                w_vga_gnt = bus.vga_req;
                w_str_gnt = bus.str_req & ~bus.vga_req;
                if (bus.vga_blank) begin
                    w_state_nxt = ST_BLANK;
                end else if ((r_starve_cnt == c_starve_trip) && bus.str_req && !w_str_gnt) begin
                    w_state_nxt = ST_FORCE;
                end
            end
            ST_BLANK: begin
                w_str_gnt = bus.str_req;
                w_vga_gnt = bus.vga_req & ~bus.str_req;
                if (!bus.vga_blank) begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_FORCE: begin
                w_str_gnt   = bus.str_req;
                w_state_nxt = bus.vga_blank ? ST_BLANK : ST_ACTIVE;
            end
            default: begin
                w_state_nxt = ST_ACTIVE;
            end
        endcase
        if (rst) begin
            w_vga_gnt = 1'b0;
            w_str_gnt = 1'b0;
        end
    end

    // Counts consecutive refused stream cycles; holds at its ceiling rather than wrapping.
    always_ff @(posedge clk) begin
        if (rst || !bus.str_req || w_str_gnt) begin
            r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_starve_sat) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    assign w_any_gnt  = w_vga_gnt | w_str_gnt;
    assign w_gnt_addr = w_vga_gnt ? bus.vga_addr : bus.str_addr;
    assign w_gnt_oob  = ({1'b0, w_gnt_addr} >= c_num_pixels);

    always_comb begin
        w_tag_in = FB_TAG_IDLE;
        if (w_vga_gnt) begin
            w_tag_in.req = REQ_VGA;
        end else if (w_str_gnt) begin
            w_tag_in.req = REQ_STR;
        end
        w_tag_in.oob = w_any_gnt & w_gnt_oob;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ram_rd_en     <= 1'b0;
            r_ram_addr      <= '0;
            r_oob_err       <= 1'b0;
            r_str_grant_cnt <= '0;
        end else begin
            r_ram_rd_en <= w_any_gnt & ~w_gnt_oob;
            if (w_any_gnt) begin
                r_ram_addr <= w_gnt_addr;
            end
            if (w_any_gnt && w_gnt_oob) begin
                r_oob_err <= 1'b1;
            end
            if (w_str_gnt && (r_str_grant_cnt != 16'hFFFF)) begin
                r_str_grant_cnt <= r_str_grant_cnt + 16'd1;
            end
        end
    end

    fb_tag_pipe #(
        .DEPTH (c_pipe_depth)
    ) u_tag_pipe (
        .clk   (clk),
        .rst   (rst),
        .i_tag (w_tag_in),
        .o_tag (w_tag_out)
    );

    assign w_vga_rvalid = ~rst & (w_tag_out.req == REQ_VGA);
    assign w_str_rvalid = ~rst & (w_tag_out.req == REQ_STR);
    // Out-of-range slots still return, but with zero data instead of whatever the RAM drives.
    assign w_rdata = ((w_vga_rvalid | w_str_rvalid) && !w_tag_out.oob) ? bus.ram_rdata : '0;

    assign bus.vga_gnt       = w_vga_gnt;
    assign bus.str_gnt       = w_str_gnt;
    assign bus.vga_rvalid    = w_vga_rvalid;
    assign bus.str_rvalid    = w_str_rvalid;
    assign bus.ram_rd_en     = r_ram_rd_en;
    assign bus.ram_addr      = r_ram_addr;
    assign bus.rdata         = w_rdata;
    assign bus.oob_err       = r_oob_err;
    assign bus.str_grant_cnt = r_str_grant_cnt;

endmodule
`default_nettype wire
